// File: rtl/pipeline_ctrl.sv
// Hazard and flush controller: Mealy stall/kill controls for the pipeline latches,
// plus a wait-state FSM (multiply occupancy, D-cache miss) and a stall-cycle counter.
module pipeline_ctrl #(
  parameter int MUL_LATENCY = 3,
  parameter int CNT_W       = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  dec_rs1_addr_i,
  input  logic [4:0]  dec_rs2_addr_i,
  input  logic        dec_uses_rs1_i,
  input  logic        dec_uses_rs2_i,
  input  logic [4:0]  exe_write_addr_i,
  input  logic        exe_int_write_enable_i,
  input  logic        exe_is_load_i,
  input  logic        exe_is_mul_i,
  input  logic        exe_branch_taken_i,
  input  logic        dcache_miss_i,
  input  logic        dcache_ready_i,
  input  logic        exc_i,
  output logic        stall_core_o,
  output logic        stall_front_o,
  output logic        kill_fetch_dec_o,
  output logic        kill_dec_exe_o,
  output logic        kill_exe_mem_o,
  output logic        pc_redirect_o,
  output logic        exc_redirect_o,
  output logic [31:0] stall_count_o
);

  typedef enum logic [1:0] {RUN, MUL_WAIT, MISS_WAIT} state_e;

  // Entering MUL_WAIT already accounts for the first stall cycle spent in RUN.
  localparam logic [CNT_W-1:0] MUL_LOAD = (MUL_LATENCY > 1) ? CNT_W'(MUL_LATENCY - 2) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] mulCnt_q, mulCnt_d;
  logic [31:0]      stallCount_q;
  logic             loadUse;
  logic             evalRun;

  assign loadUse = exe_is_load_i && exe_int_write_enable_i && (exe_write_addr_i != 5'd0) &&
                   ((dec_uses_rs1_i && (dec_rs1_addr_i == exe_write_addr_i)) ||
                    (dec_uses_rs2_i && (dec_rs2_addr_i == exe_write_addr_i)));

  // Outputs and next state; the miss-release cycle reuses the RUN priority chain.
  always_comb begin
    stall_core_o     = 1'b0;
    stall_front_o    = 1'b0;
    kill_fetch_dec_o = 1'b0;
    kill_dec_exe_o   = 1'b0;
    kill_exe_mem_o   = 1'b0;
    pc_redirect_o    = 1'b0;
    exc_redirect_o   = 1'b0;
    state_d          = state_q;
    mulCnt_d         = mulCnt_q;
    evalRun          = 1'b0;
    if (rst_i) begin
      state_d  = RUN;
      mulCnt_d = '0;
    end else if (exc_i) begin
      kill_fetch_dec_o = 1'b1;
      kill_dec_exe_o   = 1'b1;
      kill_exe_mem_o   = 1'b1;
      exc_redirect_o   = 1'b1;
      state_d          = RUN;
      mulCnt_d         = '0;
    end else begin
      case (state_q)
        RUN: evalRun = 1'b1;
        MUL_WAIT: begin
          if (mulCnt_q != '0) begin
            stall_core_o = 1'b1;
            mulCnt_d     = mulCnt_q - 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        MISS_WAIT: begin
          if (!dcache_ready_i) begin
            stall_core_o = 1'b1;
          end else begin
            evalRun = 1'b1;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
      if (evalRun) begin
        if (exe_branch_taken_i) begin
          kill_fetch_dec_o = 1'b1;
          kill_dec_exe_o   = 1'b1;
          pc_redirect_o    = 1'b1;
        end else if (dcache_miss_i && (state_q == RUN)) begin
          stall_core_o = 1'b1;
          state_d      = MISS_WAIT;
        end else if (exe_is_mul_i && (MUL_LATENCY > 1)) begin
          stall_core_o = 1'b1;
          mulCnt_d     = MUL_LOAD;
          state_d      = MUL_WAIT;
        end else if (loadUse) begin
          stall_front_o  = 1'b1;
          kill_dec_exe_o = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      mulCnt_q     <= '0;
      stallCount_q <= '0;
    end else begin
      state_q  <= state_d;
      mulCnt_q <= mulCnt_d;
      if (stall_core_o) stallCount_q <= stallCount_q + 32'd1;
    end
  end

  assign stall_count_o = stallCount_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: one instance with MUL_LATENCY=3, one with MUL_LATENCY=1.
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1, rs2, waddr;
  logic        usesRs1, usesRs2, intWe, isLoad, isMul, branch, miss, ready, exc;

  logic        stallCore, stallFront, kfd, kde, kem, pcr, excr;
  logic [31:0] stallCount;
  logic        stallCore1, stallFront1, kfd1, kde1, kem1, pcr1, excr1;
  logic [31:0] stallCount1;
  logic [6:0]  outs, outs1;

  int errors = 0;
  int checks = 0;

  pipeline_ctrl #(.MUL_LATENCY(3), .CNT_W(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .dec_rs1_addr_i(rs1), .dec_rs2_addr_i(rs2),
    .dec_uses_rs1_i(usesRs1), .dec_uses_rs2_i(usesRs2),
    .exe_write_addr_i(waddr), .exe_int_write_enable_i(intWe),
    .exe_is_load_i(isLoad), .exe_is_mul_i(isMul), .exe_branch_taken_i(branch),
    .dcache_miss_i(miss), .dcache_ready_i(ready), .exc_i(exc),
    .stall_core_o(stallCore), .stall_front_o(stallFront),
    .kill_fetch_dec_o(kfd), .kill_dec_exe_o(kde), .kill_exe_mem_o(kem),
    .pc_redirect_o(pcr), .exc_redirect_o(excr), .stall_count_o(stallCount)
  );

  pipeline_ctrl #(.MUL_LATENCY(1), .CNT_W(2)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .dec_rs1_addr_i(rs1), .dec_rs2_addr_i(rs2),
    .dec_uses_rs1_i(usesRs1), .dec_uses_rs2_i(usesRs2),
    .exe_write_addr_i(waddr), .exe_int_write_enable_i(intWe),
    .exe_is_load_i(isLoad), .exe_is_mul_i(isMul), .exe_branch_taken_i(branch),
    .dcache_miss_i(miss), .dcache_ready_i(ready), .exc_i(exc),
    .stall_core_o(stallCore1), .stall_front_o(stallFront1),
    .kill_fetch_dec_o(kfd1), .kill_dec_exe_o(kde1), .kill_exe_mem_o(kem1),
    .pc_redirect_o(pcr1), .exc_redirect_o(excr1), .stall_count_o(stallCount1)
  );

  // {stall_core, stall_front, kill_fd, kill_de, kill_em, pc_redirect, exc_redirect}
  assign outs  = {stallCore, stallFront, kfd, kde, kem, pcr, excr};
  assign outs1 = {stallCore1, stallFront1, kfd1, kde1, kem1, pcr1, excr1};

  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] STALL = 7'b1000000;
  localparam logic [6:0] LDUSE = 7'b0101000;
  localparam logic [6:0] BRNCH = 7'b0011010;
  localparam logic [6:0] EXCPT = 7'b0011101;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge and return all inputs to idle.
  task automatic applyStimulus();
    @(negedge clk);
    rst = 1'b0; rs1 = 5'd0; rs2 = 5'd0; usesRs1 = 1'b0; usesRs2 = 1'b0;
    waddr = 5'd0; intWe = 1'b0; isLoad = 1'b0; isMul = 1'b0; branch = 1'b0;
    miss = 1'b0; ready = 1'b0; exc = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rs1 = 5'd0; rs2 = 5'd0; usesRs1 = 1'b0; usesRs2 = 1'b0;
    waddr = 5'd0; intWe = 1'b0; isLoad = 1'b0; isMul = 1'b0; branch = 1'b0;
    miss = 1'b0; ready = 1'b0; exc = 1'b0;

    for (int i = 0; i < 2; i++) begin
      applyStimulus(); rst = 1'b1; isMul = 1'b1; miss = 1'b1; #1;
      checkOutput("rst_outs", 32'(outs), 32'(NONE));
      checkOutput("rst_count", stallCount, 32'd0);
    end

    applyStimulus(); isMul = 1'b1; #1;
    checkOutput("mul_c0", 32'(outs), 32'(STALL));
    checkOutput("mul1_nostall", 32'(outs1), 32'(NONE));
    applyStimulus(); isMul = 1'b1; #1;
    checkOutput("mul_c1", 32'(outs), 32'(STALL));
    applyStimulus(); isMul = 1'b1; #1;
    checkOutput("mul_release", 32'(outs), 32'(NONE));
    applyStimulus(); #1;
    checkOutput("mul_count", stallCount, 32'd2);
    checkOutput("mul1_count", stallCount1, 32'd0);

    applyStimulus(); isLoad = 1'b1; intWe = 1'b1; waddr = 5'd5;
    rs1 = 5'd3; usesRs1 = 1'b1; rs2 = 5'd5; usesRs2 = 1'b1; #1;
    checkOutput("lduse_hit", 32'(outs), 32'(LDUSE));
    applyStimulus(); rs2 = 5'd5; usesRs2 = 1'b1; #1;
    checkOutput("lduse_after", 32'(outs), 32'(NONE));
    applyStimulus(); isLoad = 1'b1; intWe = 1'b1; waddr = 5'd0; rs2 = 5'd0; usesRs2 = 1'b1; #1;
    checkOutput("lduse_x0", 32'(outs), 32'(NONE));
    applyStimulus(); isLoad = 1'b1; intWe = 1'b1; waddr = 5'd7; rs1 = 5'd7; usesRs1 = 1'b0; #1;
    checkOutput("lduse_unused", 32'(outs), 32'(NONE));
    checkOutput("lduse_count", stallCount, 32'd2);

    applyStimulus(); miss = 1'b1; #1;
    checkOutput("miss_start", 32'(outs), 32'(STALL));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(); #1;
      checkOutput("miss_wait", 32'(outs), 32'(STALL));
    end
    applyStimulus(); ready = 1'b1; #1;
    checkOutput("miss_ready", 32'(outs), 32'(NONE));
    applyStimulus(); #1;
    checkOutput("miss_count", stallCount, 32'd7);

    applyStimulus(); miss = 1'b1; #1;
    checkOutput("missbr_start", 32'(outs), 32'(STALL));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(); branch = 1'b1; #1;
      checkOutput("missbr_wait", 32'(outs), 32'(STALL));
    end
    applyStimulus(); branch = 1'b1; ready = 1'b1; #1;
    checkOutput("missbr_ready", 32'(outs), 32'(BRNCH));
    applyStimulus(); ready = 1'b1; #1;
    checkOutput("ready_in_run", 32'(outs), 32'(NONE));
    checkOutput("missbr_count", stallCount, 32'd12);

    applyStimulus(); isMul = 1'b1; #1;
    checkOutput("mulexc_c0", 32'(outs), 32'(STALL));
    applyStimulus(); isMul = 1'b1; exc = 1'b1; #1;
    checkOutput("mulexc_exc", 32'(outs), 32'(EXCPT));
    applyStimulus(); #1;
    checkOutput("mulexc_run", 32'(outs), 32'(NONE));
    checkOutput("mulexc_count", stallCount, 32'd13);

    applyStimulus(); exc = 1'b1; branch = 1'b1; #1;
    checkOutput("exc_branch", 32'(outs), 32'(EXCPT));
    applyStimulus(); branch = 1'b1; #1;
    checkOutput("branch", 32'(outs), 32'(BRNCH));
    applyStimulus(); branch = 1'b1; isMul = 1'b1; #1;
    checkOutput("branch_mul", 32'(outs), 32'(BRNCH));

    applyStimulus(); miss = 1'b1; isMul = 1'b1; #1;
    checkOutput("missmul_start", 32'(outs), 32'(STALL));
    applyStimulus(); ready = 1'b1; isMul = 1'b1; #1;
    checkOutput("missmul_ready", 32'(outs), 32'(STALL));
    applyStimulus(); isMul = 1'b1; #1;
    checkOutput("missmul_mulwait", 32'(outs), 32'(STALL));
    applyStimulus(); isMul = 1'b1; #1;
    checkOutput("missmul_release", 32'(outs), 32'(NONE));
    applyStimulus(); #1;
    checkOutput("missmul_count", stallCount, 32'd16);

    applyStimulus();
    force dut.stallCount_q = 32'hFFFF_FFFF;
    #1 release dut.stallCount_q;
    #1 checkOutput("wrap_preload", stallCount, 32'hFFFF_FFFF);
    applyStimulus(); isMul = 1'b1; #1;
    checkOutput("wrap_stall", 32'(outs), 32'(STALL));
    applyStimulus(); isMul = 1'b1; #1;
    checkOutput("wrap_zero", stallCount, 32'd0);
    applyStimulus(); #1;
    checkOutput("wrap_one", stallCount, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and flush controller for the in-order pipeline. It generates the stall and kill controls consumed by the fetch/decode, decode/execute and execute/memory pipeline latches.
- Resolves load-use hazards, multi-cycle multiply occupancy, D-cache miss waits, taken branches and exceptions.
- Holds a small wait-state machine and a stall-cycle performance counter.
- Control outputs are Mealy (combinational from registered state plus current inputs), so they act at the same clock edge as the latches they drive.

Parameters:
MUL_LATENCY, 3, cycles a multiply occupies EXE (integer >= 1; 1 means no stall)
CNT_W, 2, width of multiply wait counter; must satisfy 2**CNT_W > MUL_LATENCY

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
dec_rs1_addr_i  in  5  source register 1 of instruction in DEC
dec_rs2_addr_i  in  5  source register 2 of instruction in DEC
dec_uses_rs1_i  in  1  DEC instruction reads rs1
dec_uses_rs2_i  in  1  DEC instruction reads rs2
exe_write_addr_i  in  5  destination register of instruction in EXE
exe_int_write_enable_i  in  1  EXE instruction writes the integer register file
exe_is_load_i  in  1  EXE instruction is a load
exe_is_mul_i  in  1  EXE instruction is a multiply
exe_branch_taken_i  in  1  EXE resolved a taken branch/jump
dcache_miss_i  in  1  MEM-stage D-cache miss (pulse or level)
dcache_ready_i  in  1  miss refill complete (1-cycle pulse)
exc_i  in  1  exception raised (any stage)
stall_core_o  out  1  freeze all pipeline latches
stall_front_o  out  1  freeze PC and fetch/decode latch only
kill_fetch_dec_o  out  1  bubble into fetch/decode latch
kill_dec_exe_o  out  1  bubble into decode/execute latch
kill_exe_mem_o  out  1  bubble into execute/memory latch
pc_redirect_o  out  1  fetch takes branch target
exc_redirect_o  out  1  fetch takes exception vector
stall_count_o  out  32  cycles with stall_core_o=1

Behaviour:
- States: RUN, MUL_WAIT, MISS_WAIT. Reset (rst_i=1 at a posedge) forces state to RUN, mul counter to 0 and stall_count_o to 0.
- While rst_i=1, all 1-bit outputs are driven to 0.
- RUN evaluation, strict priority (first match wins; all unlisted outputs are 0):
  1. exc_i: kill_fetch_dec_o, kill_dec_exe_o, kill_exe_mem_o and exc_redirect_o all =1; next state RUN.
  2. exe_branch_taken_i: kill_fetch_dec_o=1, kill_dec_exe_o=1, pc_redirect_o=1.
  3. dcache_miss_i: stall_core_o=1; next state MISS_WAIT.
  4. exe_is_mul_i and MUL_LATENCY>1: stall_core_o=1; counter loads MUL_LATENCY-2; next state MUL_WAIT.
  5. Load-use hazard: stall_front_o=1 and kill_dec_exe_o=1, state unchanged. The hazard condition is all of:
     - exe_is_load_i=1, exe_int_write_enable_i=1 and exe_write_addr_i!=0;
     - (dec_uses_rs1_i=1 and dec_rs1_addr_i==exe_write_addr_i) or (dec_uses_rs2_i=1 and dec_rs2_addr_i==exe_write_addr_i).
- stall_core_o and any kill output are never 1 in the same cycle; kills take precedence and the stall is dropped.
- MUL_WAIT:
  - exc_i: same as RUN rule 1, counter cleared, next state RUN (multiply aborted).
  - Counter != 0: stall_core_o=1, counter decrements.
  - Counter == 0: stall released (stall_core_o=0), next state RUN.
  - Result: total stall cycles for one multiply = MUL_LATENCY-1; the multiply spends MUL_LATENCY cycles in EXE.
- MISS_WAIT:
  - exc_i: same as RUN rule 1, next state RUN.
  - dcache_ready_i=0: stall_core_o=1; branch, mul and miss inputs are ignored.
  - dcache_ready_i=1 (release cycle): evaluated exactly as RUN with dcache_miss_i treated as 0. A branch or multiply waiting in EXE is therefore honoured, and a multiply may enter MUL_WAIT directly.
- dcache_ready_i outside MISS_WAIT is ignored. dcache_miss_i held high is only acted on in RUN.
- stall_count_o increments by 1 at every posedge where stall_core_o=1 and rst_i=0. It wraps 0xFFFFFFFF -> 0. Load-use stalls are not counted.

Test Plan:
- Reset: rst_i=1 for 2 cycles with exe_is_mul_i=1 and dcache_miss_i=1 -> all outputs 0, stall_count_o=0; first cycle after release with exe_is_mul_i=1 -> stall_core_o=1.
- Load-use: exe load writes x5, DEC rs2=x5 with uses_rs2=1 -> exactly 1 cycle of stall_front_o=1 and kill_dec_exe_o=1. Same with exe_write_addr_i=0 -> no stall.
- Multiply, MUL_LATENCY=3: exe_is_mul_i held -> stall_core_o high for 2 cycles then low; stall_count_o=2. Repeat with MUL_LATENCY=1 -> no stall.
- Miss: dcache_miss_i pulse, dcache_ready_i 5 cycles later -> stall_core_o=1 for 5 cycles, 0 in the ready cycle; branch_taken during the wait -> no redirect until the ready cycle, then pc_redirect_o=1 and both front kills =1.
- Exception mid-wait: exc_i 1 cycle into MUL_WAIT -> all three kills and exc_redirect_o=1, stall_core_o=0, state RUN next cycle. Exception and branch together -> only exc_redirect_o=1.
- Counter wrap: preload via 2**32-1 stall cycles (or force the register) -> one more stall cycle gives stall_count_o=0.
